// File: rtl/ntsc_pkg.sv
// Shared types and constants for the BT.656 front-end decoder.
package ntsc_pkg;

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_FF   = 2'd1,
        S_Z1   = 2'd2,
        S_Z2   = 2'd3
    } state_t;

    localparam logic [7:0] CODE_FF        = 8'hFF;
    localparam logic [7:0] CODE_00        = 8'h00;
    localparam logic [7:0] CHROMA_DEFAULT = 8'h80;

    // Chroma phase: Cb, Y, Cr, Y
    localparam logic [1:0] PH_CB = 2'd0;
    localparam logic [1:0] PH_Y0 = 2'd1;
    localparam logic [1:0] PH_CR = 2'd2;
    localparam logic [1:0] PH_Y1 = 2'd3;

    function automatic logic [3:0] prot_bits(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/ntsc_xy_check.sv
// Combinational XY decode; protection bits are checked only with NTSC656_PROT_CHECK_EN.
module ntsc_xy_check
    import ntsc_pkg::*;
(
    input  logic [7:0] xy_i,
    output logic [2:0] fvh_o,
    output logic       valid_o
);

`ifdef NTSC656_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic prot_ok;

    assign fvh_o   = xy_i[6:4];
    assign prot_ok = (xy_i[3:0] == prot_bits(xy_i[6], xy_i[5], xy_i[4]));
    assign valid_o = xy_i[7] & (prot_ok | ~PROT_EN);

endmodule

// File: rtl/ntsc656_decode.sv
// BT.656 byte-stream parser: timing codes to fvh/sav/eav, active video to 24-bit YCrCb pixels.
// Optional NTSC656_PROT_CHECK_EN enables XY protection checking and the err_cnt port.
//
// state  | meaning
// S_DATA | ordinary byte; pixel data when active, 0xFF starts a code
// S_FF   | seen FF, expecting first 00
// S_Z1   | seen FF 00, expecting second 00
// S_Z2   | seen FF 00 00, current byte is XY
module ntsc656_decode
    import ntsc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  tv_data,
    output logic [2:0]  fvh,
    output logic        dv,
    output logic [23:0] ycrcb,
    output logic        sav,
    output logic        eav,
    output logic        locked
`ifdef NTSC656_PROT_CHECK_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    state_t      state_q, state_d;
    logic [2:0]  fvh_q, fvh_d;
    logic        dv_q, dv_d;
    logic [23:0] ycrcb_q, ycrcb_d;
    logic        sav_q, sav_d;
    logic        eav_q, eav_d;
    logic        locked_q, locked_d;
    logic        active_q, active_d;
    logic [1:0]  phase_q, phase_d;
    logic [7:0]  cb_q, cb_d;
    logic [7:0]  cr_q, cr_d;
`ifdef NTSC656_PROT_CHECK_EN
    logic [7:0]  err_q, err_d;
`endif

    logic [2:0]  xy_fvh;
    logic        xy_valid;

    ntsc_xy_check u_xy_check (
        .xy_i    (tv_data),
        .fvh_o   (xy_fvh),
        .valid_o (xy_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_DATA;
            fvh_q    <= 3'b000;
            dv_q     <= 1'b0;
            ycrcb_q  <= 24'h0;
            sav_q    <= 1'b0;
            eav_q    <= 1'b0;
            locked_q <= 1'b0;
            active_q <= 1'b0;
            phase_q  <= PH_CB;
            cb_q     <= CHROMA_DEFAULT;
            cr_q     <= CHROMA_DEFAULT;
`ifdef NTSC656_PROT_CHECK_EN
            err_q    <= 8'h0;
`endif
        end else begin
            state_q  <= state_d;
            fvh_q    <= fvh_d;
            dv_q     <= dv_d;
            ycrcb_q  <= ycrcb_d;
            sav_q    <= sav_d;
            eav_q    <= eav_d;
            locked_q <= locked_d;
            active_q <= active_d;
            phase_q  <= phase_d;
            cb_q     <= cb_d;
            cr_q     <= cr_d;
`ifdef NTSC656_PROT_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        fvh_d    = fvh_q;
        dv_d     = 1'b0;
        ycrcb_d  = ycrcb_q;
        sav_d    = 1'b0;
        eav_d    = 1'b0;
        locked_d = locked_q;
        active_d = active_q;
        phase_d  = phase_q;
        cb_d     = cb_q;
        cr_d     = cr_q;
`ifdef NTSC656_PROT_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            S_DATA: begin
                if (tv_data == CODE_FF) begin
                    state_d = S_FF;
                end else if (active_q) begin
                    phase_d = phase_q + 2'd1;
                    case (phase_q)
                        PH_CB:   cb_d = tv_data;
                        PH_CR:   cr_d = tv_data;
                        default: begin
                            dv_d    = 1'b1;
                            ycrcb_d = {tv_data, cr_q, cb_q};
                        end
                    endcase
                end
            end
            S_FF: begin
                if (tv_data == CODE_00) begin
                    state_d = S_Z1;
                end else begin
                    state_d  = S_DATA;
                    active_d = 1'b0;
                end
            end
            S_Z1: begin
                if (tv_data == CODE_00) begin
                    state_d = S_Z2;
                end else begin
                    state_d  = S_DATA;
                    active_d = 1'b0;
                end
            end
            S_Z2: begin
                state_d = S_DATA;
                if (xy_valid) begin
                    fvh_d    = xy_fvh;
                    locked_d = 1'b1;
                    sav_d    = ~xy_fvh[0];
                    eav_d    = xy_fvh[0];
                    active_d = ~xy_fvh[0];
                    phase_d  = PH_CB;
                    cb_d     = CHROMA_DEFAULT;
                    cr_d     = CHROMA_DEFAULT;
                end else begin
                    // A rejected code counts as an abort; fvh keeps its last good value.
                    active_d = 1'b0;
`ifdef NTSC656_PROT_CHECK_EN
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
`endif
                end
            end
            default: state_d = S_DATA;
        endcase
    end

    assign fvh     = fvh_q;
    assign dv      = dv_q;
    assign ycrcb   = ycrcb_q;
    assign sav     = sav_q;
    assign eav     = eav_q;
    assign locked  = locked_q;
`ifdef NTSC656_PROT_CHECK_EN
    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_ntsc656_decode.sv
// Directed self-checking bench for ntsc656_decode; covers the NTSC656_PROT_CHECK_EN build when defined.
module tb_ntsc656_decode;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  tv_data;
    logic [2:0]  fvh;
    logic        dv;
    logic [23:0] ycrcb;
    logic        sav;
    logic        eav;
    logic        locked;
`ifdef NTSC656_PROT_CHECK_EN
    logic [7:0]  err_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    ntsc656_decode dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tv_data (tv_data),
        .fvh     (fvh),
        .dv      (dv),
        .ycrcb   (ycrcb),
        .sav     (sav),
        .eav     (eav),
        .locked  (locked)
`ifdef NTSC656_PROT_CHECK_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Present one byte; return 1 time unit after the edge that samples it.
    task automatic put(input logic [7:0] b);
        tv_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic code(input logic [7:0] xy);
        put(8'hFF);
        put(8'h00);
        put(8'h00);
        put(xy);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] cb_v, y0_v, cr_v, y1_v, prev_cr;

    initial begin
        reset_n = 1'b0;
        tv_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fvh", 32'(fvh), 32'h0);
        check("rst_dv", 32'(dv), 32'h0);
        check("rst_ycrcb", 32'(ycrcb), 32'h0);
        check("rst_sav", 32'(sav), 32'h0);
        check("rst_eav", 32'(eav), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
`ifdef NTSC656_PROT_CHECK_EN
        check("rst_err_cnt", 32'(err_cnt), 32'h0);
`endif
        reset_n = 1'b1;

        // data before any code must not produce pixels
        put(8'h80); put(8'h10);
        check("prelock_dv", 32'(dv), 32'h0);

        // first SAV and pixel pair with default chroma
        code(8'h80);
        check("sav1_locked", 32'(locked), 32'h1);
        check("sav1_fvh", 32'(fvh), 32'h0);
        check("sav1_sav", 32'(sav), 32'h1);
        check("sav1_eav", 32'(eav), 32'h0);
        put(8'h80);
        check("sav1_c1_dv", 32'(dv), 32'h0);
        check("sav1_pulse_end", 32'(sav), 32'h0);
        put(8'h10);
        check("sav1_c3_dv", 32'(dv), 32'h1);
        check("sav1_c3_px", 32'(ycrcb), 32'h108080);
        put(8'h80);
        check("sav1_c4_dv", 32'(dv), 32'h0);
        put(8'h10);
        check("sav1_c5_dv", 32'(dv), 32'h1);
        check("sav1_c5_px", 32'(ycrcb), 32'h108080);

        // phase wrap across 8 pixels with distinct bytes per group
        code(8'h80);
        prev_cr = 8'h80;
        for (int k = 0; k < 4; k++) begin
            cb_v = 8'h40 + 8'(k);
            y0_v = 8'h50 + 8'(k);
            cr_v = 8'h60 + 8'(k);
            y1_v = 8'h70 + 8'(k);
            put(cb_v);
            check("wrap_cb_dv", 32'(dv), 32'h0);
            put(y0_v);
            check("wrap_y0_dv", 32'(dv), 32'h1);
            check("wrap_y0_px", 32'(ycrcb), {8'h00, y0_v, prev_cr, cb_v});
            put(cr_v);
            check("wrap_cr_dv", 32'(dv), 32'h0);
            put(y1_v);
            check("wrap_y1_dv", 32'(dv), 32'h1);
            check("wrap_y1_px", 32'(ycrcb), {8'h00, y1_v, cr_v, cb_v});
            prev_cr = cr_v;
        end

        // EAV mid-stream, blanking bytes emit nothing
        put(8'h40);
        code(8'h9D);
        check("eav_pulse", 32'(eav), 32'h1);
        check("eav_no_sav", 32'(sav), 32'h0);
        check("eav_fvh", 32'(fvh), 32'h1);
        put(8'h80);
        check("blank_dv0", 32'(dv), 32'h0);
        check("eav_pulse_end", 32'(eav), 32'h0);
        put(8'h10);
        check("blank_dv1", 32'(dv), 32'h0);

        // abort during an active line
        code(8'h80);
        put(8'h80); put(8'h10);
        check("pre_abort_dv", 32'(dv), 32'h1);
        put(8'hFF);
        check("abort_ff_dv", 32'(dv), 32'h0);
        put(8'h00);
        put(8'h45);
        check("abort_dv", 32'(dv), 32'h0);
        check("abort_fvh", 32'(fvh), 32'h0);
        check("abort_no_sav", 32'(sav), 32'h0);
        put(8'h80); put(8'h10);
        check("post_abort_dv0", 32'(dv), 32'h0);
        put(8'h80); put(8'h10);
        check("post_abort_dv1", 32'(dv), 32'h0);
        code(8'h80);
        put(8'h20); put(8'h30);
        check("resume_dv", 32'(dv), 32'h1);
        check("resume_px", 32'(ycrcb), 32'h308020);

`ifdef NTSC656_PROT_CHECK_EN
        code(8'h9C);
        check("bad_err_cnt", 32'(err_cnt), 32'h1);
        check("bad_fvh", 32'(fvh), 32'h0);
        check("bad_eav", 32'(eav), 32'h0);
        put(8'h80); put(8'h10);
        check("bad_abort_dv", 32'(dv), 32'h0);
        for (int i = 0; i < 255; i++) code(8'h9C);
        check("err_sat_255", 32'(err_cnt), 32'hFF);
        code(8'h9C);
        check("err_sat_hold", 32'(err_cnt), 32'hFF);
`else
        code(8'h9C);
        check("noprot_eav", 32'(eav), 32'h1);
        check("noprot_fvh", 32'(fvh), 32'h1);
        code(8'h00);
        check("bit7_clear_fvh", 32'(fvh), 32'h1);
        check("bit7_clear_sav", 32'(sav), 32'h0);
`endif

        // asynchronous reset in the middle of an active line
        code(8'h80);
        put(8'h80); put(8'h10);
        check("prerst_dv", 32'(dv), 32'h1);
        tv_data = 8'h80;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_dv", 32'(dv), 32'h0);
        check("async_ycrcb", 32'(ycrcb), 32'h0);
        check("async_locked", 32'(locked), 32'h0);
        check("async_fvh", 32'(fvh), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        put(8'h80); put(8'h10);
        check("postrst_dv0", 32'(dv), 32'h0);
        put(8'h80); put(8'h10);
        check("postrst_dv1", 32'(dv), 32'h0);
        check("postrst_locked", 32'(locked), 32'h0);
        code(8'h80);
        check("postrst_sav", 32'(sav), 32'h1);
        put(8'h22); put(8'h33);
        check("postrst_resume_dv", 32'(dv), 32'h1);
        check("postrst_resume_px", 32'(ycrcb), 32'h338022);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
